// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock-enable generator.
// NCH independent dividers in the single clk domain. Each channel produces a
// divided level (clk_out), a one-cycle strobe on its rising edge (ce) and a
// stable flag. Divisors are loaded at runtime and take effect at the next
// period boundary so a period in flight always completes unchanged.
// Optional feature macro: CLK_DIV_GEN_FALL_CE_EN adds the ce_fall strobe port.

// One divider channel. All outputs are registered and are derived from the
// next-state counter/divisor, so they describe the cycle the counter enters.
module clk_div_gen_ch #(
    parameter int             CW      = 16,
    parameter logic [CW-1:0]  DIV_RST = 16'd4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          resync,
    input  logic          ld_hit,
    input  logic [CW-1:0] ld_div,
    output logic          clk_out,
    output logic          ce,
    output logic          stable
`ifdef CLK_DIV_GEN_FALL_CE_EN
    ,
    output logic          ce_fall
`endif
);

    // Divisors below 2 cannot form a high and a low phase; force them to 2.
    function automatic logic [CW-1:0] clamp_div(input logic [CW-1:0] v);
        return (v < CW'(2)) ? CW'(2) : v;
    endfunction

    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] div_act, div_act_nxt;
    logic [CW-1:0] div_pend, div_pend_nxt;
    logic          running, running_nxt;
    logic          armed, armed_nxt;
    logic          stable_nxt;
    logic          clk_out_nxt;
    logic          ce_nxt;
    logic          wrap;
`ifdef CLK_DIV_GEN_FALL_CE_EN
    logic          ce_fall_nxt;
`endif

    // Next-state: stop/clear, (re)start or resync, period wrap, or count.
    // 'armed' means the current period began at the current divisor, so
    // the wrap ending it completes a full period and may raise stable.
    always_comb begin
        div_pend_nxt = ld_hit ? clamp_div(ld_div) : div_pend;
        wrap         = (cnt == div_act - CW'(1));
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        running_nxt  = running;
        armed_nxt    = armed;
        stable_nxt   = stable;
        if (!run) begin
            // Stopped: everything cleared, loads take effect immediately.
            cnt_nxt     = '0;
            div_act_nxt = div_pend_nxt;
            running_nxt = 1'b0;
            armed_nxt   = 1'b0;
            stable_nxt  = 1'b0;
        end else if (!running || resync) begin
            // Start (first cycle after run rises) and resync both begin a
            // fresh full period at the pending divisor, including a load
            // arriving in this same cycle.
            cnt_nxt     = '0;
            div_act_nxt = div_pend_nxt;
            running_nxt = 1'b1;
            armed_nxt   = 1'b1;
            stable_nxt  = 1'b0;
        end else if (wrap) begin
            // Period boundary: pending divisor (bypassing a same-cycle load)
            // becomes active; the ending period counts only if it was armed
            // and no load is being accepted now.
            cnt_nxt     = '0;
            div_act_nxt = div_pend_nxt;
            armed_nxt   = 1'b1;
            stable_nxt  = armed && !ld_hit;
        end else begin
            cnt_nxt = cnt + CW'(1);
            if (ld_hit) begin
                armed_nxt  = 1'b0;
                stable_nxt = 1'b0;
            end
        end
    end

    // Output decode from next state; nothing is asserted while stopped.
    always_comb begin
        clk_out_nxt = running_nxt && (cnt_nxt < (div_act_nxt >> 1));
        ce_nxt      = running_nxt && (cnt_nxt == '0);
`ifdef CLK_DIV_GEN_FALL_CE_EN
        ce_fall_nxt = running_nxt && (cnt_nxt == (div_act_nxt >> 1));
`endif
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= DIV_RST;
            div_pend <= DIV_RST;
            running  <= 1'b0;
            armed    <= 1'b0;
            stable   <= 1'b0;
            clk_out  <= 1'b0;
            ce       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_act_nxt;
            div_pend <= div_pend_nxt;
            running  <= running_nxt;
            armed    <= armed_nxt;
            stable   <= stable_nxt;
            clk_out  <= clk_out_nxt;
            ce       <= ce_nxt;
        end
    end

`ifdef CLK_DIV_GEN_FALL_CE_EN
    // Falling-edge strobe register.
    always_ff @(posedge clk) begin
        if (reset) ce_fall <= 1'b0;
        else       ce_fall <= ce_fall_nxt;
    end
`endif

endmodule

// Top level: channel array plus load-strobe decode.
module clk_div_gen #(
    parameter int NCH      = 2,
    parameter int CW       = 16,
    parameter int DIV_INIT = 4,
    localparam int LW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           resync,
    input  logic           ld,
    input  logic [LW-1:0]  ld_ch,
    input  logic [CW-1:0]  ld_div,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] ce,
    output logic [NCH-1:0] stable
`ifdef CLK_DIV_GEN_FALL_CE_EN
    ,
    output logic [NCH-1:0] ce_fall
`endif
);

    localparam logic [CW-1:0] DIV_RST = (DIV_INIT < 2) ? CW'(2) : CW'(DIV_INIT);

    logic [NCH-1:0] ld_hit;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // An ld_ch value at or above NCH matches no channel and is dropped.
        assign ld_hit[g] = ld && (ld_ch == LW'(g));

        clk_div_gen_ch #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .run     (run),
            .resync  (resync),
            .ld_hit  (ld_hit[g]),
            .ld_div  (ld_div),
            .clk_out (clk_out[g]),
            .ce      (ce[g]),
            .stable  (stable[g])
`ifdef CLK_DIV_GEN_FALL_CE_EN
            ,
            .ce_fall (ce_fall[g])
`endif
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen (NCH=3 so an out-of-range
// ld_ch value is representable). Expected waveforms are hand-written bit
// vectors with cycle 0 in the MSB.
module tb_clk_div_gen;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int LW  = 2;

    logic           clk;
    logic           reset;
    logic           run;
    logic           resync;
    logic           ld;
    logic [LW-1:0]  ld_ch;
    logic [CW-1:0]  ld_div;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] stable;
`ifdef CLK_DIV_GEN_FALL_CE_EN
    logic [NCH-1:0] ce_fall;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_gen #(.NCH(NCH), .CW(CW), .DIV_INIT(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .resync  (resync),
        .ld      (ld),
        .ld_ch   (ld_ch),
        .ld_div  (ld_div),
        .clk_out (clk_out),
        .ce      (ce),
        .stable  (stable)
`ifdef CLK_DIV_GEN_FALL_CE_EN
        ,
        .ce_fall (ce_fall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with run held high; returns at the sample point of cycle 0.
    task automatic start_run();
        reset = 1'b1; run = 1'b1; resync = 1'b0; ld = 1'b0; ld_ch = '0; ld_div = '0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    // Reset with run low, load ch0/ch1 while stopped, then start; returns in cycle 0.
    task automatic start_stopped(input logic [CW-1:0] d0, input logic [CW-1:0] d1);
        reset = 1'b1; run = 1'b0; resync = 1'b0; ld = 1'b0; ld_ch = '0; ld_div = '0;
        step(); step();
        reset = 1'b0;
        ld = 1'b1; ld_ch = 2'd0; ld_div = d0;
        step();
        ld_ch = 2'd1; ld_div = d1;
        step();
        ld = 1'b0; run = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [11:0] e_ce, e_clk, e_st;
        reset = 1'b1; run = 1'b1; resync = 1'b0; ld = 1'b0; ld_ch = '0; ld_div = '0;
        step(); step();
        checks++;
        if ({clk_out, ce, stable} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b expected=0", {clk_out, ce, stable});
        end
        reset = 1'b0;
        step();
        e_ce  = 12'b1000_1000_1000;
        e_clk = 12'b1100_1100_1100;
        e_st  = 12'b0000_1111_1111;
        for (int n = 0; n < 12; n++) begin
            checks++;
            if (ce !== {3{e_ce[11-n]}}) begin
                failures++;
                $display("FAIL reset_ce cycle=%0d got=%b expected=%b", n, ce, {3{e_ce[11-n]}});
            end
            checks++;
            if (clk_out !== {3{e_clk[11-n]}}) begin
                failures++;
                $display("FAIL reset_clk cycle=%0d got=%b expected=%b", n, clk_out, {3{e_clk[11-n]}});
            end
            checks++;
            if (stable !== {3{e_st[11-n]}}) begin
                failures++;
                $display("FAIL reset_stable cycle=%0d got=%b expected=%b", n, stable, {3{e_st[11-n]}});
            end
            step();
        end
    endtask

    task automatic test_load();
        logic [14:0] e_ce, e_clk, e_st;
        start_run();
        e_ce  = 15'b1000_10000_10000_1;
        e_clk = 15'b1100_11000_11000_1;
        e_st  = 15'b0000_00000_11111_1;
        for (int n = 0; n < 15; n++) begin
            ld = (n == 1); ld_ch = 2'd0; ld_div = 16'd5;
            checks++;
            if (ce[0] !== e_ce[14-n]) begin
                failures++;
                $display("FAIL load_ce cycle=%0d got=%b expected=%b", n, ce[0], e_ce[14-n]);
            end
            checks++;
            if (clk_out[0] !== e_clk[14-n]) begin
                failures++;
                $display("FAIL load_clk cycle=%0d got=%b expected=%b", n, clk_out[0], e_clk[14-n]);
            end
            checks++;
            if (stable[0] !== e_st[14-n]) begin
                failures++;
                $display("FAIL load_stable cycle=%0d got=%b expected=%b", n, stable[0], e_st[14-n]);
            end
            step();
        end
        ld = 1'b0;
    endtask

    task automatic test_clamp();
        logic [11:0] e_ce0, e_clk0, e_st0, e_ce2;
        start_run();
        e_ce0  = 12'b1000_1010_1010;
        e_clk0 = 12'b1100_1010_1010;
        e_st0  = 12'b0000_0011_1111;
        e_ce2  = 12'b1000_1000_1000;
        for (int n = 0; n < 12; n++) begin
            ld = (n < 3);
            ld_ch  = (n == 2) ? 2'd3 : 2'd0;
            ld_div = (n == 0) ? 16'd0 : (n == 1) ? 16'd1 : 16'd7;
            checks++;
            if (ce[0] !== e_ce0[11-n]) begin
                failures++;
                $display("FAIL clamp_ce cycle=%0d got=%b expected=%b", n, ce[0], e_ce0[11-n]);
            end
            checks++;
            if (clk_out[0] !== e_clk0[11-n]) begin
                failures++;
                $display("FAIL clamp_clk cycle=%0d got=%b expected=%b", n, clk_out[0], e_clk0[11-n]);
            end
            checks++;
            if (stable[0] !== e_st0[11-n]) begin
                failures++;
                $display("FAIL clamp_stable cycle=%0d got=%b expected=%b", n, stable[0], e_st0[11-n]);
            end
            checks++;
            if (ce[2:1] !== {2{e_ce2[11-n]}}) begin
                failures++;
                $display("FAIL oor_ce cycle=%0d got=%b expected=%b", n, ce[2:1], {2{e_ce2[11-n]}});
            end
            step();
        end
        ld = 1'b0;
    endtask

    // Two loads in one period, the second in the boundary cycle itself.
    task automatic test_back_to_back();
        logic [9:0] e_ce, e_clk;
        start_run();
        e_ce  = 10'b1000_100_100;
        e_clk = 10'b1100_100_100;
        for (int n = 0; n < 10; n++) begin
            ld = (n == 0) || (n == 3); ld_ch = 2'd0;
            ld_div = (n == 0) ? 16'd7 : 16'd3;
            checks++;
            if (ce[0] !== e_ce[9-n]) begin
                failures++;
                $display("FAIL b2b_ce cycle=%0d got=%b expected=%b", n, ce[0], e_ce[9-n]);
            end
            checks++;
            if (clk_out[0] !== e_clk[9-n]) begin
                failures++;
                $display("FAIL b2b_clk cycle=%0d got=%b expected=%b", n, clk_out[0], e_clk[9-n]);
            end
            step();
        end
        ld = 1'b0;
    endtask

    task automatic test_resync();
        logic [23:0] e_ce0, e_ce1, e_st1;
        start_stopped(16'd4, 16'd6);
        e_ce0 = 24'b1000_1000_1000_1000_1000_1000;
        e_ce1 = 24'b100000_1_0_1_00000_1_00000_1_000;
        e_st1 = 24'b000000_11_000000_1111111111;
        for (int n = 0; n < 24; n++) begin
            resync = (n == 7);
            checks++;
            if (ce[1:0] !== {e_ce1[23-n], e_ce0[23-n]}) begin
                failures++;
                $display("FAIL resync_ce cycle=%0d got=%b expected=%b", n, ce[1:0], {e_ce1[23-n], e_ce0[23-n]});
            end
            checks++;
            if (stable[1] !== e_st1[23-n]) begin
                failures++;
                $display("FAIL resync_stable cycle=%0d got=%b expected=%b", n, stable[1], e_st1[23-n]);
            end
            step();
        end
        resync = 1'b0;
    endtask

    task automatic test_reset_stop();
        logic [7:0] e_ce;
        logic [5:0] e_d3;
        start_stopped(16'd6, 16'd4);
        step(); step();
        // cycle 2 of a D=6 period
        reset = 1'b1;
        step();
        checks++;
        if ({clk_out, ce, stable} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b expected=0", {clk_out, ce, stable});
        end
        reset = 1'b0;
        step();
        e_ce = 8'b1000_1000;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (ce[0] !== e_ce[7-n]) begin
                failures++;
                $display("FAIL midreset_div cycle=%0d got=%b expected=%b", n, ce[0], e_ce[7-n]);
            end
            if (n == 4) begin
                run = 1'b0;
                step();
                checks++;
                if ({clk_out, ce, stable} !== '0) begin
                    failures++;
                    $display("FAIL stop_outputs got=%b expected=0", {clk_out, ce, stable});
                end
                break;
            end
            step();
        end
        ld = 1'b1; ld_ch = 2'd0; ld_div = 16'd3;
        step();
        ld = 1'b0; run = 1'b1;
        step();
        e_d3 = 6'b100_100;
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (ce[0] !== e_d3[5-n]) begin
                failures++;
                $display("FAIL restart_ce cycle=%0d got=%b expected=%b", n, ce[0], e_d3[5-n]);
            end
            checks++;
            if (clk_out[0] !== e_d3[5-n]) begin
                failures++;
                $display("FAIL restart_clk cycle=%0d got=%b expected=%b", n, clk_out[0], e_d3[5-n]);
            end
            step();
        end
    endtask

`ifdef CLK_DIV_GEN_FALL_CE_EN
    task automatic test_fall();
        logic [12:0] e_f;
        start_stopped(16'd5, 16'd4);
        e_f = 13'b00100_00100_001;
        for (int n = 0; n < 13; n++) begin
            checks++;
            if (ce_fall[0] !== e_f[12-n]) begin
                failures++;
                $display("FAIL ce_fall cycle=%0d got=%b expected=%b", n, ce_fall[0], e_f[12-n]);
            end
            step();
        end
        run = 1'b0;
        step();
        checks++;
        if (ce_fall !== '0) begin
            failures++;
            $display("FAIL ce_fall_stopped got=%b expected=0", ce_fall);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; run = 1'b0; resync = 1'b0; ld = 1'b0; ld_ch = '0; ld_div = '0;
        test_reset();
        test_load();
        test_clamp();
        test_back_to_back();
        test_resync();
        test_reset_stop();
`ifdef CLK_DIV_GEN_FALL_CE_EN
        test_fall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Multi-channel programmable clock-enable generator for the display/BRAM datapath. It replaces the fixed divide-by-4 25 MHz generator with NCH independent dividers, each with a runtime-loadable divisor. Each channel produces a divided clock level, a one-cycle enable strobe and a stable flag, all in the single `clk` domain. Downstream logic uses `ce` as a clock enable; `clk_out` is for observation or pin output only and is not used as a fabric clock.

## Interface

- `NCH`, 2, number of divider channels (1..8)
- `CW`, 16, divisor/counter width in bits
- `DIV_INIT`, 4, reset divisor for every channel; clamped to ≥2 (4 at 100 MHz gives 25 MHz)

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `run`  in  1  global run; low stops and clears all channels
- `resync`  in  1  one-cycle pulse; phase-realigns all channels
- `ld`  in  1  divisor load strobe
- `ld_ch`  in  max(1,$clog2(NCH))  target channel for `ld`
- `ld_div`  in  CW  new divisor value
- `clk_out`  out  NCH  divided clock level per channel
- `ce`  out  NCH  one-cycle strobe coinciding with the `clk_out` rising edge
- `stable`  out  NCH  channel has completed a full period at its current divisor
- `ce_fall`  out  NCH  falling-edge strobe; present only with `CLK_DIV_GEN_FALL_CE_EN`

## Operation

- Per-channel state: counter `cnt` (0..D−1), active divisor D, pending divisor P, stable flag. All outputs are registered.
- Divisor rule: any loaded value <2 (including 0) is clamped to 2. Maximum divisor is 2^CW−1.
- Waveform, period D:
  - `clk_out`=1 while `cnt` < D>>1, 0 otherwise; odd D gives a shorter high phase.
  - `ce`=1 when `cnt`==0.
- Load:
  - `ld`=1 with `ld_ch`<NCH writes P[`ld_ch`] and clears that channel's `stable` the next cycle.
  - `ld_ch`≥NCH: the load is ignored.
  - Repeated loads before the period boundary: the last load wins.
  - P becomes D at the next period boundary (next `cnt`==0). The current period always completes unchanged, so there is no runt pulse.
- `stable` rises together with the `ce` that ends the first full period at the current D. It is cleared by reset, `run`=0, an accepted load or `resync`.
- `run`=0:
  - All `cnt`, `clk_out`, `ce` and `stable` are held at 0.
  - Loads apply immediately (D←P).
  - When `run` rises, operation restarts as from cycle 0.
- `resync`=1 (with `run`=1):
  - Every channel sets `cnt`=0 on that edge, so all `ce` fire in the same cycle.
  - Pending P are applied; all `stable` clear.
  - `ld` in the same cycle as `resync`: the new value is applied at the resync.
- Priority: `reset` > `run`=0 > `resync` > normal counting.

## Timing

- Reset values: `clk_out`=0, `ce`=0, `stable`=0, `ce_fall`=0, `cnt`=0, D=P=clamp(DIV_INIT).
- Cycle 0 is the clock period after the first edge at which `reset`=0 and `run`=1 are sampled.
- In cycle n: `ce`=1 iff n mod D == 0; `clk_out`=1 iff n mod D < D>>1.
- Latency from `run` rising to the first `ce` is 1 clock. After reset with `run` held high, `stable` rises in cycle D.
- A load accepted in cycle k takes effect at the first boundary after k. `stable` rises one full new period after that boundary.
- `reset` or `run`=0 asserted mid-period: all outputs are 0 in the next cycle, with no completion of the period.
- D=2: `clk_out` toggles every cycle and `ce` fires every 2 cycles.

## Configuration

- `CLK_DIV_GEN_FALL_CE_EN` defined:
  - Adds the `ce_fall` port.
  - `ce_fall`=1 for one cycle when `cnt`==D>>1, i.e. the cycle `clk_out` goes low.
  - Never asserted while `run`=0 or during reset.
- `CLK_DIV_GEN_FALL_CE_EN` not defined: no `ce_fall` port and no logic for it; all other behaviour is identical.

## Test plan

- DIV_INIT=4, release reset, `run`=1 → `ce`[0] in cycles 0,4,8; `clk_out`[0] pattern 1,1,0,0; `stable`[0] rises in cycle 4.
- Load `ld_div`=5 to ch0 in cycle 1 → cycles 0..3 keep D=4; from cycle 4, high 2 / low 3; `stable` low cycles 2..8, high again in cycle 9.
- Load `ld_div`=0, then 1, then `ld_ch`=NCH with value 7 → clamped to D=2 (`clk_out` 1,0,1,0; `ce` every 2 cycles); the out-of-range load changes nothing.
- ch0 D=4, ch1 D=6, pulse `resync` in cycle 7 → both `ce` the next cycle, then coincident every 12 cycles.
- Assert `reset` in cycle 2 of a D=6 period → next cycle all outputs are 0 and D returns to DIV_INIT. Drop `run` mid-period and load 3 while stopped → `run` rise gives `ce` after 1 clock with D=3.
- With `CLK_DIV_GEN_FALL_CE_EN` and D=5 → `ce_fall` in cycles 2,7,12; without the macro the `ce_fall` port is absent.
